// File: rtl/spi_slave_rx_tx.sv
// spi_slave_rx_tx: oversampling SPI mode-0 target.
// SCLK/SDI/SEN are synchronized into BUS_CLK, MSB-first words are assembled
// into a small RX FIFO, and words from a one-entry TX holding register are
// shifted out on SDO, changing after each falling SCLK edge.
module spi_slave_rx_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  BUS_CLK,
    input  logic                  BUS_RST_N,
    input  logic                  SCLK,
    input  logic                  SDI,
    input  logic                  SEN,
    output logic                  SDO,
    input  logic [DATA_WIDTH-1:0] TX_DATA,
    input  logic                  TX_VALID,
    output logic                  TX_READY,
    output logic [DATA_WIDTH-1:0] RX_DATA,
    output logic                  RX_VALID,
    input  logic                  RX_READY,
    output logic                  RX_OVERFLOW,
    output logic                  TX_UNDERRUN,
    input  logic                  CLEAR_ERR,
    output logic                  BUSY
);

    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // synchronizer and edge-detect flops
    logic sclk_meta_r, sclk_sync_r, sclk_dly_r;
    logic sen_meta_r, sen_sync_r, sen_dly_r;
    logic sdi_meta_r, sdi_sync_r;

    // frame engine state
    state_t                 state_r;
    logic [CNT_W-1:0]       bit_cnt_r;
    logic [DATA_WIDTH-1:0]  rx_sr_r;
    logic [DATA_WIDTH-1:0]  tx_sr_r;
    logic                   reload_pend_r;
    logic                   sdo_r;
    logic                   busy_r;

    // TX holding register
    logic [DATA_WIDTH-1:0]  hold_r;
    logic                   hold_full_r;

    // RX FIFO
    logic [DATA_WIDTH-1:0]  fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [PTR_W:0]         count_r;
    logic [DATA_WIDTH-1:0]  rx_data_r;
    logic                   rx_valid_r;

    // sticky error flags
    logic                   overflow_r;
    logic                   underrun_r;

    // decoded events
    logic                   sclk_rise_s, sclk_fall_s;
    logic                   sen_rise_s, sen_fall_s;
    logic                   load_s;
    logic [DATA_WIDTH-1:0]  load_word_s;
    logic                   underrun_evt_s;
    logic                   tx_wr_s;
    logic                   push_s;
    logic [DATA_WIDTH-1:0]  push_data_s;
    logic                   fifo_full_s;
    logic                   pop_s;
    logic                   push_ok_s;
    logic                   overflow_evt_s;
    logic [PTR_W-1:0]       rd_ptr_next_s;
    logic [PTR_W:0]         count_next_s;
    logic [DATA_WIDTH-1:0]  head_next_s;

    assign sclk_rise_s = sclk_sync_r & ~sclk_dly_r;
    assign sclk_fall_s = ~sclk_sync_r & sclk_dly_r;
    assign sen_rise_s  = sen_sync_r & ~sen_dly_r;
    assign sen_fall_s  = ~sen_sync_r & sen_dly_r;

    // Synchronize the SPI pins; SEN chain resets high so a frame already open at reset release is ignored
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            sclk_meta_r <= 1'b0;
            sclk_sync_r <= 1'b0;
            sclk_dly_r  <= 1'b0;
            sen_meta_r  <= 1'b1;
            sen_sync_r  <= 1'b1;
            sen_dly_r   <= 1'b1;
            sdi_meta_r  <= 1'b0;
            sdi_sync_r  <= 1'b0;
        end else begin
            sclk_meta_r <= SCLK;
            sclk_sync_r <= sclk_meta_r;
            sclk_dly_r  <= sclk_sync_r;
            sen_meta_r  <= SEN;
            sen_sync_r  <= sen_meta_r;
            sen_dly_r   <= sen_sync_r;
            sdi_meta_r  <= SDI;
            sdi_sync_r  <= sdi_meta_r;
        end
    end

    // Decode which frame events load the TX shifter or push a finished RX word this cycle
    always_comb begin
        load_s      = 1'b0;
        push_s      = 1'b0;
        push_data_s = {rx_sr_r[DATA_WIDTH-2:0], sdi_sync_r};
        case (state_r)
            ST_IDLE: begin
                if (sen_rise_s) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (sen_fall_s) begin
                    load_s = 1'b0;
                    push_s = 1'b0;
                end else begin
                    if (sclk_rise_s && (bit_cnt_r == LAST_BIT)) begin
                        push_s = 1'b1;
                    end else begin
                        push_s = 1'b0;
                    end
                    if (sclk_fall_s && reload_pend_r) begin
                        load_s = 1'b1;
                    end else begin
                        load_s = 1'b0;
                    end
                end
            end
            default: begin
                load_s = 1'b0;
                push_s = 1'b0;
            end
        endcase
    end

    // A load sees the holding register as it was before any same-cycle write
    assign load_word_s    = hold_full_r ? hold_r : {DATA_WIDTH{1'b0}};
    assign underrun_evt_s = load_s & ~hold_full_r;
    assign tx_wr_s        = TX_VALID & ~hold_full_r;

    // Frame state machine: bit counting, RX assembly, TX shifting and the registered SDO
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state_r       <= ST_IDLE;
            bit_cnt_r     <= {CNT_W{1'b0}};
            rx_sr_r       <= {DATA_WIDTH{1'b0}};
            tx_sr_r       <= {DATA_WIDTH{1'b0}};
            reload_pend_r <= 1'b0;
            sdo_r         <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (sen_rise_s) begin
                        state_r       <= ST_ACTIVE;
                        busy_r        <= 1'b1;
                        bit_cnt_r     <= {CNT_W{1'b0}};
                        reload_pend_r <= 1'b0;
                        tx_sr_r       <= load_word_s;
                        sdo_r         <= load_word_s[DATA_WIDTH-1];
                    end else begin
                        busy_r        <= 1'b0;
                        sdo_r         <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (sen_fall_s) begin
                        state_r       <= ST_IDLE;
                        busy_r        <= 1'b0;
                        bit_cnt_r     <= {CNT_W{1'b0}};
                        reload_pend_r <= 1'b0;
                        sdo_r         <= 1'b0;
                    end else if (sclk_rise_s) begin
                        rx_sr_r <= push_data_s;
                        if (bit_cnt_r == LAST_BIT) begin
                            bit_cnt_r     <= {CNT_W{1'b0}};
                            reload_pend_r <= 1'b1;
                        end else begin
                            bit_cnt_r     <= bit_cnt_r + CNT_W'(1);
                        end
                    end else if (sclk_fall_s) begin
                        if (reload_pend_r) begin
                            tx_sr_r       <= load_word_s;
                            sdo_r         <= load_word_s[DATA_WIDTH-1];
                            reload_pend_r <= 1'b0;
                        end else begin
                            tx_sr_r       <= {tx_sr_r[DATA_WIDTH-2:0], 1'b0};
                            sdo_r         <= tx_sr_r[DATA_WIDTH-2];
                        end
                    end else begin
                        busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    sdo_r   <= 1'b0;
                end
            endcase
        end
    end

    // TX holding register: a load empties it, a write (only when empty) fills it
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            hold_r      <= {DATA_WIDTH{1'b0}};
            hold_full_r <= 1'b0;
        end else begin
            if (tx_wr_s) begin
                hold_r      <= TX_DATA;
                hold_full_r <= 1'b1;
            end else if (load_s) begin
                hold_full_r <= 1'b0;
            end else begin
                hold_full_r <= hold_full_r;
            end
        end
    end

    assign fifo_full_s    = (count_r == FIFO_FULL);
    assign pop_s          = rx_valid_r & RX_READY;
    assign push_ok_s      = push_s & (~fifo_full_s | pop_s);
    assign overflow_evt_s = push_s & fifo_full_s & ~pop_s;

    // Work out FIFO occupancy and the head word as they will be after this cycle
    always_comb begin
        rd_ptr_next_s = rd_ptr_r;
        count_next_s  = count_r;
        head_next_s   = {DATA_WIDTH{1'b0}};
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        case ({push_ok_s, pop_s})
            2'b10:   count_next_s = count_r + (PTR_W + 1)'(1);
            2'b01:   count_next_s = count_r - (PTR_W + 1)'(1);
            default: count_next_s = count_r;
        endcase
        if (push_ok_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_next_s = push_data_s;
        end else begin
            head_next_s = fifo_mem_r[rd_ptr_next_s];
        end
    end

    // RX FIFO storage, pointers and registered head/valid outputs
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {(PTR_W + 1){1'b0}};
            rx_data_r  <= {DATA_WIDTH{1'b0}};
            rx_valid_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                fifo_mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r             <= wr_ptr_r;
            end
            rd_ptr_r   <= rd_ptr_next_s;
            count_r    <= count_next_s;
            rx_data_r  <= head_next_s;
            rx_valid_r <= (count_next_s != {(PTR_W + 1){1'b0}});
        end
    end

    // Sticky error flags; a new event wins over a coincident clear
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            overflow_r <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            overflow_r <= overflow_evt_s | (overflow_r & ~CLEAR_ERR);
            underrun_r <= underrun_evt_s | (underrun_r & ~CLEAR_ERR);
        end
    end

    assign SDO         = sdo_r;
    assign TX_READY    = ~hold_full_r;
    assign RX_DATA     = rx_data_r;
    assign RX_VALID    = rx_valid_r;
    assign RX_OVERFLOW = overflow_r;
    assign TX_UNDERRUN = underrun_r;
    assign BUSY        = busy_r;

endmodule

// File: doc/spi_slave_rx_tx.md
# spi_slave_rx_tx

Oversampling SPI target (slave) for the far end of the team's `spi` master link. It samples the incoming SCLK/SDI/SEN lines in the local clock domain, deserializes MSB-first words into a small RX FIFO, and serializes words from a one-entry TX holding register onto SDO. It is used as the device-side model/peripheral that answers the `spi` master and feeds `fast_spi_rx`-style loopback checks.

## Interface
Parameters:
- DATA_WIDTH, 8, word length in bits (≥2)
- FIFO_DEPTH, 4, RX FIFO entries (power of 2, ≥2)

Ports:
- BUS_CLK  in  1  system clock; all logic on rising edge
- BUS_RST_N  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- SCLK  in  1  SPI clock from master, asynchronous, idle low (mode 0)
- SDI  in  1  master-to-slave data, asynchronous
- SEN  in  1  frame enable, active high, asynchronous
- SDO  out  1  slave-to-master data, registered
- TX_DATA  in  DATA_WIDTH  next word to send
- TX_VALID  in  1  TX_DATA valid
- TX_READY  out  1  holding register empty
- RX_DATA  out  DATA_WIDTH  FIFO head word
- RX_VALID  out  1  FIFO not empty
- RX_READY  in  1  pop FIFO head when RX_VALID
- RX_OVERFLOW  out  1  sticky: received word dropped, FIFO full
- TX_UNDERRUN  out  1  sticky: word load found holding register empty
- CLEAR_ERR  in  1  clears both sticky flags
- BUSY  out  1  synchronized SEN high (frame in progress)

## Operation
- SCLK, SDI, SEN each pass a 2-flop synchronizer; SCLK and SEN feed a third flop for edge detection. Edge flops reset to 1 for SEN (no false start if SEN high at reset release) and 0 for SCLK.
- States: IDLE, ACTIVE.
- IDLE -> ACTIVE on SEN rising edge: bit_cnt=0; tx_sr loaded from holding register (holding emptied) or, if empty, loaded 0 and TX_UNDERRUN set; SDO = tx_sr MSB.
- ACTIVE, SCLK rising: rx_sr shifts left taking synchronized SDI; bit_cnt++. At bit_cnt == DATA_WIDTH-1 the assembled word is pushed to the FIFO, bit_cnt wraps to 0, reload_pend set.
- ACTIVE, SCLK falling: if reload_pend, tx_sr loaded from holding (or 0 + TX_UNDERRUN), reload_pend cleared; else tx_sr shifts left (LSB filled 0). SDO follows new MSB.
- ACTIVE -> IDLE on SEN falling edge: partial word discarded (no push), bit_cnt=0, reload_pend=0, SDO=0. SCLK edges in IDLE ignored.
- Holding register: write when TX_VALID & TX_READY. Load in the same cycle as a write sees pre-write state (empty -> underrun; write then fills holding).
- FIFO: push when full and no pop -> word dropped, RX_OVERFLOW set. Push and pop same cycle when full -> both succeed, count unchanged. Pop when RX_VALID & RX_READY.
- CLEAR_ERR coincident with a new error event: flag remains set.
- Reset mid-frame: all state cleared; a new frame starts only after SEN is seen low then high.

## Timing
- Reset values: SDO=0, TX_READY=1, RX_DATA=0, RX_VALID=0, RX_OVERFLOW=0, TX_UNDERRUN=0, BUSY=0.
- Pin edge to detected edge: 3 BUS_CLK (2 sync + detect).
- Last SCLK rising pin edge to RX_VALID/RX_DATA update: ≤4 BUS_CLK.
- SCLK falling pin edge to SDO change: ≤4 BUS_CLK; SEN rising pin edge to first SDO bit: ≤4 BUS_CLK.
- Supported input: SCLK high and low phases each ≥6 BUS_CLK; SEN setup to first SCLK rising ≥6 BUS_CLK.
- TX_DATA for word n+1 must be written before the falling SCLK edge following word n's last bit.
- RX_READY/TX_VALID handshakes take effect the same cycle; RX_DATA updates the cycle after pop.

## Test plan
- Reset: drive BUS_RST_N low with SEN=1, SCLK toggling -> all outputs at reset values; after release no word pushed until SEN low->high.
- Single frame: preload TX 0xA5, master sends 0x3C -> RX_DATA=0x3C, RX_VALID=1, master captures 0xA5, no flags.
- Three-word frame, TX 0x11, 0x22 supplied, third not supplied; master sends 0x01,0x02,0x03 -> FIFO 0x01,0x02,0x03; SDO 0x11,0x22,0x00; TX_UNDERRUN=1.
- RX_READY=0, five words 0x10..0x14 -> FIFO holds 0x10..0x13, RX_OVERFLOW=1; pulse CLEAR_ERR -> 0; drain returns 0x10..0x13 in order.
- SEN drops after 5 bits, then full frame 0x5A -> no push from partial frame, next RX_DATA=0x5A.
- Full FIFO with RX_READY=1 on the same cycle as push -> count stays 4, no overflow, oldest word popped.
